// File: rtl/ring_mon_pkg.sv
// Shared types and word helpers for the ring sequence monitor.
// Helpers work on a MAX_W-bit container; callers zero-extend narrower rings.
package ring_mon_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int unsigned MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  // Rotate the low 'width' bits by one place; dir=0 left, dir=1 right.
  function automatic word_t rot(input word_t word, input int unsigned width, input logic dir);
    word_t mask;
    word_t r;
    mask = (width >= MAX_W) ? '1 : ((word_t'(1) << width) - word_t'(1));
    if (dir) r = (word >> 1) | (word << (width - 1));
    else     r = (word << 1) | (word >> (width - 1));
    return r & mask;
  endfunction

  function automatic logic is_onehot(input word_t word);
    return (word != '0) && ((word & (word - word_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index encoder, purely combinational (0 cycles, no flow control).
// vld flags an exactly-one-hot input; idx is only meaningful when vld=1.
module onehot_to_bin
  import ring_mon_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int IW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  output logic [IW-1:0]    idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (din[i]) idx = idx | IW'(i);
    end
    vld = is_onehot(word_t'(din));
  end

endmodule

// File: rtl/ring_sequence_monitor.sv
// Status tap on a rotating one-hot ring: lock detect, revolution and loss counters.
// Latency 1 cycle (all outputs registered); no backpressure, samples din every edge.
module ring_sequence_monitor
  import ring_mon_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIR    = 0,
  parameter int LOCK_N = 2,
  parameter int REV_W  = 8,
  parameter int ERR_W  = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [WIDTH-1:0]         din,
  input  logic                     clr,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     onehot_ok,
  output logic                     locked,
  output logic                     mismatch,
  output logic [REV_W-1:0]         rev_cnt,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam int IW   = $clog2(WIDTH);
  localparam int MW   = $clog2(LOCK_N) + 1;
  localparam int WRAP = (DIR == 0) ? 0 : WIDTH - 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   prev_q, prev_d;
  logic               prev_valid_q, prev_valid_d;
  logic [MW-1:0]      match_cnt_q, match_cnt_d;
  logic [IW-1:0]      pos_q, pos_d;
  logic               onehot_ok_q, onehot_ok_d;
  logic               mismatch_q, mismatch_d;
  logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;

  logic [IW-1:0]      din_idx;
  logic               is_oh;
  word_t              expected;
  logic               step_ok;
  logic               at_wrap;

  onehot_to_bin #(.WIDTH(WIDTH)) u_enc (
    .din (din),
    .idx (din_idx),
    .vld (is_oh)
  );

  // Compared at full container width so every bit of the rotated word is checked.
  assign expected = rot(word_t'(prev_q), WIDTH, DIR != 0);
  assign step_ok  = prev_valid_q & is_oh & (word_t'(din) == expected);
  assign at_wrap  = din[WRAP];

  always_comb begin
    state_d      = state_q;
    prev_d       = din;
    prev_valid_d = 1'b1;
    match_cnt_d  = match_cnt_q;
    pos_d        = is_oh ? din_idx : pos_q;
    onehot_ok_d  = is_oh;
    mismatch_d   = 1'b0;
    rev_cnt_d    = rev_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (clr) begin
      state_d      = SEARCH;
      prev_valid_d = 1'b0;
      match_cnt_d  = '0;
      rev_cnt_d    = '0;
      err_cnt_d    = '0;
    end else begin
      case (state_q)
        SEARCH: begin
          if (step_ok) begin
            if (match_cnt_q == MW'(LOCK_N - 1)) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
              // The locking step itself may complete a revolution.
              if (at_wrap) rev_cnt_d = rev_cnt_q + 1'b1;
            end else begin
              match_cnt_d = match_cnt_q + 1'b1;
            end
          end else begin
            match_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (step_ok) begin
            if (at_wrap) rev_cnt_d = rev_cnt_q + 1'b1;
          end else begin
            state_d     = SEARCH;
            match_cnt_d = '0;
            mismatch_d  = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= SEARCH;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      match_cnt_q  <= '0;
      pos_q        <= '0;
      onehot_ok_q  <= 1'b0;
      mismatch_q   <= 1'b0;
      rev_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      match_cnt_q  <= match_cnt_d;
      pos_q        <= pos_d;
      onehot_ok_q  <= onehot_ok_d;
      mismatch_q   <= mismatch_d;
      rev_cnt_q    <= rev_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign pos       = pos_q;
  assign onehot_ok = onehot_ok_q;
  assign locked    = (state_q == LOCKED);
  assign mismatch  = mismatch_q;
  assign rev_cnt   = rev_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ring_sequence_monitor.sv
// Directed plus randomized bench for ring_sequence_monitor against a behavioural model.
module tb_ring_sequence_monitor;

  localparam int W      = 4;
  localparam int DIR    = 0;
  localparam int LOCK_N = 2;
  localparam int REV_W  = 8;
  localparam int ERR_W  = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;
  localparam int REV_MOD = 1 << REV_W;

  logic                 clk;
  logic                 n_rst;
  logic [W-1:0]         din;
  logic                 clr;
  logic [$clog2(W)-1:0] pos;
  logic                 onehot_ok;
  logic                 locked;
  logic                 mismatch;
  logic [REV_W-1:0]     rev_cnt;
  logic [ERR_W-1:0]     err_cnt;

  ring_sequence_monitor #(
    .WIDTH (W), .DIR (DIR), .LOCK_N (LOCK_N), .REV_W (REV_W), .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .din       (din),
    .clr       (clr),
    .pos       (pos),
    .onehot_ok (onehot_ok),
    .locked    (locked),
    .mismatch  (mismatch),
    .rev_cnt   (rev_cnt),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  string phase = "init";

  // Reference model state, expressed as ring positions and streak counts.
  logic [W-1:0] m_prev;
  bit           m_prev_valid;
  int           m_streak;
  bit           m_locked;
  int           m_pos;
  bit           m_oh;
  bit           m_mis;
  int           m_rev;
  int           m_err;

  function automatic int hot_idx(input logic [W-1:0] w);
    int n = 0;
    int k = -1;
    for (int i = 0; i < W; i++) begin
      if (w[i] === 1'b1) begin
        n++;
        k = i;
      end
    end
    return (n == 1) ? k : -1;
  endfunction

  task automatic model_reset();
    m_prev = '0; m_prev_valid = 0; m_streak = 0; m_locked = 0;
    m_pos = 0; m_oh = 0; m_mis = 0; m_rev = 0; m_err = 0;
  endtask

  task automatic model_step(input logic [W-1:0] w, input bit c);
    int idx;
    int pidx;
    int want;
    bit good;
    bit wrap;
    idx  = hot_idx(w);
    pidx = hot_idx(m_prev);
    want = (DIR == 0) ? (pidx + 1) % W : (pidx + W - 1) % W;
    good = m_prev_valid && (idx >= 0) && (pidx >= 0) && (idx == want);
    wrap = (idx == ((DIR == 0) ? 0 : W - 1));
    m_mis = 0;
    if (c) begin
      m_streak = 0; m_locked = 0; m_rev = 0; m_err = 0;
    end else if (m_locked) begin
      if (good) begin
        if (wrap) m_rev = (m_rev + 1) % REV_MOD;
      end else begin
        m_locked = 0; m_mis = 1; m_streak = 0;
        if (m_err < ERR_MAX) m_err++;
      end
    end else if (good) begin
      m_streak++;
      if (m_streak == LOCK_N) begin
        m_locked = 1; m_streak = 0;
        if (wrap) m_rev = (m_rev + 1) % REV_MOD;
      end
    end else begin
      m_streak = 0;
    end
    m_oh = (idx >= 0);
    if (idx >= 0) m_pos = idx;
    m_prev = w;
    m_prev_valid = !c;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pos",       32'(pos),       32'(m_pos));
    chk("onehot_ok", 32'(onehot_ok), 32'(m_oh));
    chk("locked",    32'(locked),    32'(m_locked));
    chk("mismatch",  32'(mismatch),  32'(m_mis));
    chk("rev_cnt",   32'(rev_cnt),   32'(m_rev));
    chk("err_cnt",   32'(err_cnt),   32'(m_err));
  endtask

  task automatic drive(input logic [W-1:0] w, input bit c);
    @(negedge clk);
    din = w;
    clr = c;
    @(posedge clk);
    model_step(w, c);
    #1;
    check_all();
  endtask

  logic [W-1:0] cur;
  logic [W-1:0] word;
  int           r;
  int           err_seq [4] = '{1, 2, 3, 3};

  initial begin
    n_rst = 1'b0;
    din   = '0;
    clr   = 1'b0;
    model_reset();

    phase = "reset";
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("locked_rst", 32'(locked), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    phase = "lock";
    drive(4'b0001, 0); chk("pos0", 32'(pos), 32'd0);
    drive(4'b0010, 0); chk("pos1", 32'(pos), 32'd1);
    chk("not_locked_yet", 32'(locked), 32'd0);
    drive(4'b0100, 0); chk("pos2", 32'(pos), 32'd2);
    chk("locked_after_0100", 32'(locked), 32'd1);
    chk("rev0", 32'(rev_cnt), 32'd0);

    phase = "revs";
    drive(4'b1000, 0);
    drive(4'b0001, 0); chk("rev1", 32'(rev_cnt), 32'd1);
    drive(4'b0010, 0);
    drive(4'b0100, 0);
    drive(4'b1000, 0);
    drive(4'b0001, 0); chk("rev2", 32'(rev_cnt), 32'd2);
    chk("still_locked", 32'(locked), 32'd1);

    phase = "loss";
    drive(4'b0010, 0);
    drive(4'b0100, 0);
    drive(4'b0011, 0);
    chk("mis_pulse", 32'(mismatch), 32'd1);
    chk("err1", 32'(err_cnt), 32'd1);
    chk("unlocked", 32'(locked), 32'd0);
    chk("oh_bad", 32'(onehot_ok), 32'd0);
    chk("pos_hold", 32'(pos), 32'd2);
    drive(4'b0001, 0); chk("mis_one_cycle", 32'(mismatch), 32'd0);
    drive(4'b0010, 0);
    drive(4'b0100, 0); chk("relocked", 32'(locked), 32'd1);

    phase = "errsat";
    drive(4'b0001, 1);
    chk("clr_err", 32'(err_cnt), 32'd0);
    drive(4'b0010, 0);
    drive(4'b0100, 0);
    drive(4'b1000, 0);
    chk("locked_after_clr", 32'(locked), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(4'b0011, 0);
      chk("err_seq", 32'(err_cnt), 32'(err_seq[i]));
      drive(4'b0001, 0);
      drive(4'b0010, 0);
      drive(4'b0100, 0);
      chk("relock_seq", 32'(locked), 32'd1);
    end

    phase = "clr_mis";
    drive(4'b1000, 0);
    drive(4'b1000, 1);
    chk("clr_mis", 32'(mismatch), 32'd0);
    chk("clr_err0", 32'(err_cnt), 32'd0);
    chk("clr_rev0", 32'(rev_cnt), 32'd0);
    chk("clr_unlock", 32'(locked), 32'd0);

    phase = "async";
    cur = 4'b0001;
    drive(cur, 0);
    for (int i = 0; i < 40 && m_rev < 5; i++) begin
      cur = {cur[W-2:0], cur[W-1]};
      drive(cur, 0);
    end
    chk("rev5", 32'(rev_cnt), 32'd5);
    chk("locked_rev5", 32'(locked), 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_locked0", 32'(locked), 32'd0);
    chk("async_rev0", 32'(rev_cnt), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    drive(4'b0001, 0);
    drive(4'b0010, 0); chk("relock_wait", 32'(locked), 32'd0);
    drive(4'b0100, 0); chk("relock_2steps", 32'(locked), 32'd1);

    phase = "random";
    cur = 4'b0100;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 75)      word = {cur[W-2:0], cur[W-1]};
      else if (r < 82) word = cur;
      else if (r < 92) word = W'($urandom);
      else             word = W'(1) << $urandom_range(0, W - 1);
      drive(word, $urandom_range(0, 99) < 3);
      cur = word;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
